// File: rtl/alu_mc.sv
// Multi-cycle integer ALU: single-cycle base ops, optional iterative mul/div/rem.
// Define ALU_MC_MULDIV_EN to build the multiply/divide datapath.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_operand_a,
  input  logic [WIDTH-1:0] i_operand_b,
  input  logic [4:0]       i_alu_op,
  input  logic             i_kill,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_alu_data,
  output logic             o_illegal
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_data;
  logic             r_illegal;
  logic             w_accept;
  logic [WIDTH:0]   w_sub;
  logic             w_slt;
  logic [WIDTH-1:0] w_base;
  logic             w_legal;
  logic [SHW-1:0]   w_sh;

  assign o_ready    = !i_kill && ((r_state == S_IDLE) || (r_state == S_DONE && i_ready));
  assign w_accept   = i_valid && o_ready;
  assign o_valid    = (r_state == S_DONE);
  assign o_illegal  = (r_state == S_DONE) && r_illegal;
  assign o_alu_data = r_data;

  assign w_sh  = i_operand_b[SHW-1:0];
  assign w_sub = {1'b0, i_operand_a} - {1'b0, i_operand_b};
  // Signs differ: the negative operand is smaller; otherwise the difference cannot overflow.
  assign w_slt = (i_operand_a[WIDTH-1] ^ i_operand_b[WIDTH-1]) ? i_operand_a[WIDTH-1]
                                                               : w_sub[WIDTH-1];

  always_comb begin
    w_base  = '0;
    w_legal = 1'b1;
    case (i_alu_op)
      5'd0:    w_base = i_operand_a + i_operand_b;
      5'd1:    w_base = w_sub[WIDTH-1:0];
      5'd2:    w_base = {{(WIDTH-1){1'b0}}, w_slt};
      5'd3:    w_base = {{(WIDTH-1){1'b0}}, w_sub[WIDTH]};
      5'd4:    w_base = i_operand_a ^ i_operand_b;
      5'd5:    w_base = i_operand_a | i_operand_b;
      5'd6:    w_base = i_operand_a & i_operand_b;
      5'd7:    w_base = i_operand_a << w_sh;
      5'd8:    w_base = i_operand_a >> w_sh;
      5'd9:    w_base = $unsigned($signed(i_operand_a) >>> w_sh);
      default: w_legal = 1'b0;
    endcase
  end

`ifdef ALU_MC_MULDIV_EN
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_y;
  logic [WIDTH-1:0]   r_a;
  logic [2:0]         r_f3;
  logic               r_neg;
  logic               r_sa;
  logic               r_div0;
  logic [SHW-1:0]     r_cnt;

  logic               w_md_op;
  logic [2:0]         w_f3;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_rsh;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_acc_nx;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;
  logic [WIDTH-1:0]   w_md_res;

  assign w_md_op = (i_alu_op[4:3] == 2'b10);
  assign w_f3    = i_alu_op[2:0];
  assign w_sa    = i_operand_a[WIDTH-1] && !(w_f3 == 3'd3 || w_f3 == 3'd5 || w_f3 == 3'd7);
  assign w_sb    = i_operand_b[WIDTH-1] &&
                   (w_f3 == 3'd0 || w_f3 == 3'd1 || w_f3 == 3'd4 || w_f3 == 3'd6);
  assign w_mag_a = w_sa ? -i_operand_a : i_operand_a;
  assign w_mag_b = w_sb ? -i_operand_b : i_operand_b;

  // Multiply: {hi,lo} with multiplier in lo, add multiplicand into hi, shift right.
  assign w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_y : {WIDTH{1'b0}})};
  // Divide: {rem,quot} shifted left, trial-subtract divisor from the remainder.
  assign w_rsh  = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff = w_rsh - {1'b0, r_y};

  always_comb begin
    if (r_f3[2])
      w_acc_nx = w_diff[WIDTH] ? {w_rsh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                               : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    else
      w_acc_nx = {w_sum, r_acc[WIDTH-1:1]};
  end

  assign w_prod = r_neg ? -w_acc_nx : w_acc_nx;
  assign w_q    = r_neg ? -w_acc_nx[WIDTH-1:0] : w_acc_nx[WIDTH-1:0];
  assign w_r    = r_sa ? -w_acc_nx[2*WIDTH-1:WIDTH] : w_acc_nx[2*WIDTH-1:WIDTH];

  always_comb begin
    case (r_f3)
      3'd0:             w_md_res = w_prod[WIDTH-1:0];
      3'd1, 3'd2, 3'd3: w_md_res = w_prod[2*WIDTH-1:WIDTH];
      3'd4, 3'd5:       w_md_res = r_div0 ? {WIDTH{1'b1}} : w_q;
      default:          w_md_res = r_div0 ? r_a : w_r;
    endcase
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_data    <= '0;
      r_illegal <= 1'b0;
`ifdef ALU_MC_MULDIV_EN
      r_acc     <= '0;
      r_y       <= '0;
      r_a       <= '0;
      r_f3      <= '0;
      r_neg     <= 1'b0;
      r_sa      <= 1'b0;
      r_div0    <= 1'b0;
      r_cnt     <= '0;
`endif
    end else if (i_kill) begin
      r_state <= S_IDLE;
    end else if (w_accept) begin
`ifdef ALU_MC_MULDIV_EN
      if (w_md_op) begin
        r_state   <= S_BUSY;
        r_illegal <= 1'b0;
        r_f3      <= w_f3;
        r_cnt     <= '0;
        r_acc     <= {{WIDTH{1'b0}}, (w_f3[2] ? w_mag_a : w_mag_b)};
        r_y       <= w_f3[2] ? w_mag_b : w_mag_a;
        r_a       <= i_operand_a;
        r_sa      <= w_sa;
        r_neg     <= w_sa ^ w_sb;
        r_div0    <= (i_operand_b == '0);
      end else
`endif
      begin
        r_state   <= S_DONE;
        r_data    <= w_legal ? w_base : '0;
        r_illegal <= !w_legal;
      end
    end else if (r_state == S_DONE && i_ready) begin
      r_state <= S_IDLE;
    end
`ifdef ALU_MC_MULDIV_EN
    else if (r_state == S_BUSY) begin
      r_acc <= w_acc_nx;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == {SHW{1'b1}}) begin
        r_state <= S_DONE;
        r_data  <= w_md_res;
      end
    end
`endif
  end
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc; expectations follow ALU_MC_MULDIV_EN if defined.
module tb_alu_mc;
`ifdef ALU_MC_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  typedef struct packed {
    logic        ill;
    logic [31:0] d;
  } exp_t;

  logic        i_clk, i_rst_n, i_valid, o_ready, i_kill, o_valid, i_ready, o_illegal;
  logic [31:0] i_operand_a, i_operand_b, o_alu_data;
  logic [4:0]  i_alu_op;
  int          checks, failures;
  exp_t        sb[$];

  alu_mc #(.WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_operand_a(i_operand_a), .i_operand_b(i_operand_b), .i_alu_op(i_alu_op),
    .i_kill(i_kill), .o_valid(o_valid), .i_ready(i_ready), .o_alu_data(o_alu_data),
    .o_illegal(o_illegal)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  localparam int NB = 13;
  logic [4:0]  bt_op [NB] = '{5'd0, 5'd2, 5'd3, 5'd9, 5'd1, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd2, 5'd3, 5'd9};
  logic [31:0] bt_a  [NB] = '{32'h7fffffff, 32'h80000000, 32'h80000000, 32'h80000000, 32'h0,
                              32'hf0f0f0f0, 32'hf0f0f0f0, 32'hf0f0f0f0, 32'h1, 32'h80000000,
                              32'h1, 32'h1, 32'h7ffffff0};
  logic [31:0] bt_b  [NB] = '{32'h1, 32'h1, 32'h1, 32'h1f, 32'h1, 32'h0ff00ff0, 32'h0f0f0f0f,
                              32'hff00ff00, 32'h3f, 32'h24, 32'h80000000, 32'h80000000, 32'h4};
  logic [31:0] bt_e  [NB] = '{32'h80000000, 32'h1, 32'h0, 32'hffffffff, 32'hffffffff,
                              32'hff00ff00, 32'hffffffff, 32'hf000f000, 32'h80000000,
                              32'h08000000, 32'h0, 32'h1, 32'h07ffffff};

  localparam int NM = 15;
  logic [4:0]  mt_op [NM] = '{5'd17, 5'd19, 5'd16, 5'd20, 5'd22, 5'd20, 5'd22, 5'd22, 5'd18,
                              5'd21, 5'd23, 5'd20, 5'd21, 5'd23, 5'd20};
  logic [31:0] mt_a  [NM] = '{32'hffffffff, 32'hffffffff, 32'h7, 32'h7, 32'h7, 32'h80000000,
                              32'h80000000, 32'hfffffff9, 32'hffffffff, 32'd100, 32'd100,
                              32'hfffffff9, 32'h7, 32'h7, 32'hfffffff9};
  logic [31:0] mt_b  [NM] = '{32'hffffffff, 32'hffffffff, 32'hfffffffd, 32'h0, 32'h0,
                              32'hffffffff, 32'hffffffff, 32'h2, 32'hffffffff, 32'd7, 32'd7,
                              32'h2, 32'h0, 32'h0, 32'h0};
  logic [31:0] mt_e  [NM] = '{32'h0, 32'hfffffffe, 32'hffffffeb, 32'hffffffff, 32'h7,
                              32'h80000000, 32'h0, 32'hffffffff, 32'hffffffff, 32'd14, 32'd2,
                              32'hfffffffd, 32'hffffffff, 32'h7, 32'hffffffff};

  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        ill;
`ifdef ALU_MC_MULDIV_EN
    longint      sa, sb2, ub;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    ub  = longint'({32'h0, b});
`endif
    r   = '0;
    ill = 1'b0;
    case (op)
      5'd0: r = a + b;
      5'd1: r = a - b;
      5'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd3: r = (a < b) ? 32'd1 : 32'd0;
      5'd4: r = a ^ b;
      5'd5: r = a | b;
      5'd6: r = a & b;
      5'd7: r = a << b[4:0];
      5'd8: r = a >> b[4:0];
      5'd9: r = $unsigned($signed(a) >>> b[4:0]);
`ifdef ALU_MC_MULDIV_EN
      5'd16: begin p = 64'(sa * sb2); r = p[31:0]; end
      5'd17: begin p = 64'(sa * sb2); r = p[63:32]; end
      5'd18: begin p = 64'(sa * ub); r = p[63:32]; end
      5'd19: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
      5'd20: r = (b == 0) ? 32'hffffffff : (a == 32'h80000000 && b == 32'hffffffff) ? a
                 : 32'($signed(a) / $signed(b));
      5'd21: r = (b == 0) ? 32'hffffffff : a / b;
      5'd22: r = (b == 0) ? a : (a == 32'h80000000 && b == 32'hffffffff) ? 32'h0
                 : 32'($signed(a) % $signed(b));
      5'd23: r = (b == 0) ? a : a % b;
`endif
      default: ill = 1'b1;
    endcase
    return {ill, r};
  endfunction

  function automatic int exp_lat(input logic [4:0] op);
    return (MD && op[4:3] == 2'b10) ? 33 : 1;
  endfunction

  function automatic exp_t pop_exp();
    if (sb.size() == 0) return 33'bx;
    return sb.pop_front();
  endfunction

  // Issue one request with i_ready=1; returns the result and its latency (-1 on timeout).
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input exp_t x, output logic [31:0] d, output logic ill, output int lat);
    int w;
    @(negedge i_clk);
    i_valid = 1'b1; i_alu_op = op; i_operand_a = a; i_operand_b = b; i_ready = 1'b1; i_kill = 1'b0;
    #1;
    w = 0;
    while (!o_ready && w < 100) begin @(negedge i_clk); #1; w++; end
    sb.push_back(x);
    @(negedge i_clk);
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 100) begin @(negedge i_clk); lat++; end
    if (!o_valid) lat = -1;
    d   = o_alu_data;
    ill = o_illegal;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic ill; int lat; exp_t e;
    i_rst_n = 1'b0; i_valid = 1'b0; i_kill = 1'b0; i_ready = 1'b0;
    i_alu_op = '0; i_operand_a = '0; i_operand_b = '0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    checks++; if (o_alu_data !== 32'h0) begin failures++; $display("FAIL reset_data: got %h want 0", o_alu_data); end
    checks++; if (o_illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal: got %b want 0", o_illegal); end
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    run_op(5'd0, 32'd5, 32'd6, '{ill: 1'b0, d: 32'd11}, d, ill, lat);
    e = pop_exp();
    checks++; if ({ill, d} !== e) begin failures++; $display("FAIL pre_reset_add: got %h want %h", d, e.d); end
    @(negedge i_clk);
    i_valid = 1'b1; i_alu_op = 5'd20; i_operand_a = 32'd100; i_operand_b = 32'd3; i_ready = 1'b0;
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (4) @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL midop_reset_valid: got %b want 0", o_valid); end
    checks++; if (o_alu_data !== 32'h0) begin failures++; $display("FAIL midop_reset_data: got %h want 0", o_alu_data); end
    checks++; if (o_illegal !== 1'b0) begin failures++; $display("FAIL midop_reset_illegal: got %b want 0", o_illegal); end
    @(negedge i_clk);
    i_rst_n = 1'b1; i_ready = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL midop_reset_ready: got %b want 1", o_ready); end
    sb.delete();
  endtask

  task automatic test_base();
    logic [31:0] d, a, b; logic ill; int lat; exp_t e, x; logic [4:0] op;
    for (int i = 0; i < NB + 16; i++) begin
      if (i < NB) begin
        op = bt_op[i]; a = bt_a[i]; b = bt_b[i]; x = {1'b0, bt_e[i]};
      end else begin
        op = 5'($urandom_range(0, 9)); a = $urandom; b = $urandom; x = model(op, a, b);
      end
      run_op(op, a, b, x, d, ill, lat);
      e = pop_exp();
      checks++;
      if ({ill, d} !== e) begin
        failures++;
        $display("FAIL base[%0d] op=%0d: got ill=%b data=%h want ill=%b data=%h", i, op, ill, d, e.ill, e.d);
      end
      checks++; if (lat != 1) begin failures++; $display("FAIL base_lat[%0d]: got %0d want 1", i, lat); end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] d; logic ill; int lat; exp_t e;
    logic [4:0] ops [4] = '{5'd10, 5'd15, 5'd24, 5'd31};
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], 32'h5, 32'h6, '{ill: 1'b1, d: 32'h0}, d, ill, lat);
      e = pop_exp();
      checks++;
      if ({ill, d} !== e) begin
        failures++;
        $display("FAIL illegal op=%0d: got ill=%b data=%h want ill=%b data=%h", ops[i], ill, d, e.ill, e.d);
      end
      checks++; if (lat != 1) begin failures++; $display("FAIL illegal_lat op=%0d: got %0d want 1", ops[i], lat); end
    end
  endtask

  task automatic test_muldiv();
    logic [31:0] d, a, b; logic ill; int lat; exp_t e, x; logic [4:0] op;
    for (int i = 0; i < NM + 10; i++) begin
      if (i < NM) begin
        op = mt_op[i]; a = mt_a[i]; b = mt_b[i];
        x = MD ? {1'b0, mt_e[i]} : {1'b1, 32'h0};
      end else begin
        op = 5'(16 + $urandom_range(0, 7)); a = $urandom;
        b = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
        x = model(op, a, b);
      end
      run_op(op, a, b, x, d, ill, lat);
      e = pop_exp();
      checks++;
      if ({ill, d} !== e) begin
        failures++;
        $display("FAIL muldiv[%0d] op=%0d a=%h b=%h: got ill=%b data=%h want ill=%b data=%h",
                 i, op, a, b, ill, d, e.ill, e.d);
      end
      checks++;
      if (lat != exp_lat(op)) begin
        failures++; $display("FAIL muldiv_lat[%0d]: got %0d want %0d", i, lat, exp_lat(op));
      end
    end
  endtask

  task automatic test_back_to_back();
    int sent, got, cyc; exp_t e;
    sent = 0; got = 0; cyc = 0;
    i_ready = 1'b1; i_kill = 1'b0;
    while (got < 6 && cyc < 30) begin
      @(negedge i_clk);
      cyc++;
      if (o_valid) begin
        e = pop_exp();
        checks++;
        if ({o_illegal, o_alu_data} !== e) begin
          failures++; $display("FAIL b2b[%0d]: got %h want %h", got, o_alu_data, e.d);
        end
        got++;
      end
      if (sent < 6) begin
        i_valid = 1'b1; i_alu_op = 5'd0; i_operand_a = 32'(sent * 16 + 1); i_operand_b = 32'(sent);
      end else i_valid = 1'b0;
      #1;
      if (i_valid && o_ready) begin
        sb.push_back({1'b0, i_operand_a + i_operand_b});
        sent++;
      end
    end
    i_valid = 1'b0;
    checks++;
    if (got != 6 || cyc != 7) begin
      failures++; $display("FAIL b2b_rate: got %0d results in %0d cycles want 6 in 7", got, cyc);
    end
    // Stall: result held while the consumer is not ready.
    @(negedge i_clk);
    i_valid = 1'b1; i_alu_op = 5'd0; i_operand_a = 32'h1234; i_operand_b = 32'h1111; i_ready = 1'b0;
    #1;
    if (o_ready) sb.push_back({1'b0, 32'h2345});
    @(negedge i_clk);
    i_operand_a = 32'd10; i_operand_b = 32'd20;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (o_valid !== 1'b1 || o_alu_data !== 32'h2345 || o_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall[%0d]: got valid=%b data=%h ready=%b want 1/2345/0", k, o_valid, o_alu_data, o_ready);
      end
      @(negedge i_clk);
    end
    i_ready = 1'b1;
    #1;
    e = pop_exp();
    checks++;
    if (o_ready !== 1'b1 || {o_illegal, o_alu_data} !== e) begin
      failures++; $display("FAIL stall_release: got ready=%b data=%h want 1/%h", o_ready, o_alu_data, e.d);
    end
    sb.push_back({1'b0, 32'd30});
    @(negedge i_clk);
    i_valid = 1'b0;
    e = pop_exp();
    checks++;
    if (o_valid !== 1'b1 || {o_illegal, o_alu_data} !== e) begin
      failures++; $display("FAIL stall_next: got valid=%b data=%h want 1/%h", o_valid, o_alu_data, e.d);
    end
  endtask

  task automatic test_kill();
    logic [31:0] d; logic ill; int lat, seen; exp_t e;
    @(negedge i_clk);
    i_valid = 1'b1; i_alu_op = 5'd16; i_operand_a = 32'd3; i_operand_b = 32'd5; i_ready = 1'b0;
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (9) @(negedge i_clk);
    i_kill = 1'b1; i_valid = 1'b1; i_alu_op = 5'd0; i_operand_a = 32'd2; i_operand_b = 32'd3; i_ready = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL kill_ready: got %b want 0", o_ready); end
    @(negedge i_clk);
    i_kill = 1'b0; i_valid = 1'b0;
    seen = 0;
    repeat (40) begin #1; if (o_valid !== 1'b0) seen++; @(negedge i_clk); end
    checks++; if (seen != 0) begin failures++; $display("FAIL kill_no_valid: got %0d valid cycles want 0", seen); end
    i_kill = 1'b1;
    @(negedge i_clk);
    i_kill = 1'b0;
    run_op(5'd0, 32'd2, 32'd3, '{ill: 1'b0, d: 32'd5}, d, ill, lat);
    e = pop_exp();
    checks++; if ({ill, d} !== e) begin failures++; $display("FAIL kill_then_add: got %h want %h", d, e.d); end
    checks++; if (lat != 1) begin failures++; $display("FAIL kill_then_add_lat: got %0d want 1", lat); end
  endtask

  initial begin
    checks = 0; failures = 0;
    test_reset();
    test_base();
    test_illegal();
    test_back_to_back();
    test_muldiv();
    test_kill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
